// File: rtl/ace_snap_pkg.sv
// Shared definitions for the Ace snapshot loader: FSM state codes, the
// 212-bit T80 register image layout and the register-window offset decode.
// Latency: n/a (constants and a pure function). Backpressure: n/a.
package ace_snap_pkg;

  localparam int REG_IMAGE_W = 212;
  localparam int MASK_W      = 32;   // one bit per image byte, indexed by lsb/8

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_LOAD    = 2'd1;
  localparam state_t ST_WAIT_VS = 2'd2;
  localparam state_t ST_INJECT  = 2'd3;

  // Field positions inside the image
  localparam int SP_LSB   = 48;
  localparam int PC_LSB   = 64;
  localparam int IM_LSB   = 208;
  localparam int IFF1_BIT = 210;
  localparam int IFF2_BIT = 211;

  // Kind of image field an offset writes
  localparam logic [1:0] FK_NONE = 2'd0;
  localparam logic [1:0] FK_BYTE = 2'd1;
  localparam logic [1:0] FK_IM   = 2'd2;
  localparam logic [1:0] FK_BIT  = 2'd3;

  typedef struct packed {
    logic [1:0] kind;
    logic [7:0] lsb;
  } field_t;

  // Offset within the register window -> destination field in the image.
  function automatic field_t off_field(input logic [6:0] off);
    field_t f;
    f.kind = FK_BYTE;
    f.lsb  = 8'd0;
    case (off)
      7'h00: f.lsb = 8'd8;
      7'h01: f.lsb = 8'd0;
      7'h04: f.lsb = 8'd80;
      7'h05: f.lsb = 8'd88;
      7'h08: f.lsb = 8'd96;
      7'h09: f.lsb = 8'd104;
      7'h0C: f.lsb = 8'd112;
      7'h0D: f.lsb = 8'd120;
      7'h10: f.lsb = 8'd128;
      7'h11: f.lsb = 8'd136;
      7'h14: f.lsb = 8'd192;
      7'h15: f.lsb = 8'd200;
      7'h18: f.lsb = 8'd48;
      7'h19: f.lsb = 8'd56;
      7'h1C: f.lsb = 8'd64;
      7'h1D: f.lsb = 8'd72;
      7'h20: f.lsb = 8'd24;
      7'h21: f.lsb = 8'd16;
      7'h24: f.lsb = 8'd144;
      7'h25: f.lsb = 8'd152;
      7'h28: f.lsb = 8'd160;
      7'h29: f.lsb = 8'd168;
      7'h2C: f.lsb = 8'd176;
      7'h2D: f.lsb = 8'd184;
      7'h30: begin f.kind = FK_IM;  f.lsb = 8'(IM_LSB);   end
      7'h34: begin f.kind = FK_BIT; f.lsb = 8'(IFF1_BIT); end
      7'h38: begin f.kind = FK_BIT; f.lsb = 8'(IFF2_BIT); end
      7'h3C: f.lsb = 8'd32;
      7'h40: f.lsb = 8'd40;
      default: f.kind = FK_NONE;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/ace_snap_regfile.sv
// Register image capture: decodes window writes into the 212-bit image,
// tracks which bytes were captured and latches snap_valid at load end.
// Latency: a write lands in image_o one clk later. Backpressure: none.
// Ports: clear_i (wipe image/mask/valid), wr_i/off_i/data_i (window write),
// latch_i (load end: latch valid, apply sp_fix_i with sp_fix_val_i),
// image_o (register image), snap_valid_o (both PC bytes were captured).
module ace_snap_regfile
  import ace_snap_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear_i,
  input  logic                   wr_i,
  input  logic [6:0]             off_i,
  input  logic [7:0]             data_i,
  input  logic                   latch_i,
  input  logic                   sp_fix_i,
  input  logic [15:0]            sp_fix_val_i,
  output logic [REG_IMAGE_W-1:0] image_o,
  output logic                   snap_valid_o
);

  field_t                 fld;
  logic [REG_IMAGE_W-1:0] image_d, image_q;
  logic [MASK_W-1:0]      mask_d, mask_q;
  logic                   valid_d, valid_q;

  always_comb begin
    fld     = off_field(off_i);
    image_d = image_q;
    mask_d  = mask_q;
    valid_d = valid_q;
    if (clear_i) begin
      image_d = '0;
      mask_d  = '0;
      valid_d = 1'b0;
    end else begin
      if (wr_i && fld.kind != FK_NONE) begin
        mask_d[fld.lsb[7:3]] = 1'b1;
        case (fld.kind)
          FK_BYTE: image_d[fld.lsb +: 8]  = data_i;
          FK_IM:   image_d[IM_LSB +: 2]   = data_i[1:0];
          default: image_d[fld.lsb]       = data_i[0];
        endcase
      end
      // Writes are never qualified in the load-end cycle, so no overlap here.
      if (latch_i) begin
        valid_d = mask_q[PC_LSB/8] & mask_q[PC_LSB/8 + 1];
        if (sp_fix_i) image_d[SP_LSB +: 16] = sp_fix_val_i;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      image_q <= '0;
      mask_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      image_q <= image_d;
      mask_q  <= mask_d;
      valid_q <= valid_d;
    end
  end

  assign image_o      = image_q;
  assign snap_valid_o = valid_q;

endmodule

// File: rtl/ace_snap_loader.sv
// Snapshot-load sequencer: captures T80 registers from the loader stream,
// holds the CPU in reset, releases on vsync (or timeout) and strobes DIRSet.
// Latency: image +1 clk after a write; release on the vsync-edge clk. Backpressure: none.
// Ports: loader_en/addr/data/wr (loader byte stream), vsync (level),
// cpu_reset/dir_set (T80 control), reg_image (T80 DIR), busy, snap_valid, sp_fixed.
module ace_snap_loader
  import ace_snap_pkg::*;
#(
  parameter logic [15:0] REG_BASE      = 16'h2100,
  parameter int          INJECT_CYCLES = 3,
  parameter bit          SP_FIXUP      = 1'b1,
  parameter logic [15:0] SP_FIX_VALUE  = 16'hFFFE,
  parameter int          VS_TIMEOUT    = 2**20
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   loader_en,
  input  logic [15:0]            loader_addr,
  input  logic [7:0]             loader_data,
  input  logic                   loader_wr,
  input  logic                   vsync,
  output logic                   cpu_reset,
  output logic                   dir_set,
  output logic [REG_IMAGE_W-1:0] reg_image,
  output logic                   busy,
  output logic                   snap_valid,
  output logic                   sp_fixed
);

  localparam logic [20:0] TO_LAST  = 21'(VS_TIMEOUT - 1);
  localparam logic [3:0]  INJ_LAST = 4'(INJECT_CYCLES - 1);

  state_t      state_d, state_q;
  logic [15:0] max_addr_d, max_addr_q;
  logic [20:0] to_cnt_d, to_cnt_q;
  logic [3:0]  inj_cnt_d, inj_cnt_q;
  logic        sp_fixed_d, sp_fixed_q;
  logic        en_q, vs_q;

  logic en_rise, vs_rise, in_win, load_wr, load_end, load_start, sp_fix, release_now;

  assign en_rise  = loader_en & ~en_q;
  assign vs_rise  = vsync & ~vs_q;
  assign in_win   = (loader_addr[15:7] == REG_BASE[15:7]);
  assign load_wr  = (state_q == ST_LOAD) && loader_en && loader_wr;
  assign load_end = (state_q == ST_LOAD) && !loader_en;

  assign load_start = ((state_q == ST_IDLE) && loader_en) ||
                      (((state_q == ST_WAIT_VS) || (state_q == ST_INJECT)) && en_rise);

  assign sp_fix = SP_FIXUP && load_end && (reg_image[SP_LSB +: 16] > max_addr_q);

  // to_cnt_q is zero only in the WAIT_VS entry cycle, which must not use an edge.
  assign release_now = (state_q == ST_WAIT_VS) &&
                       ((vs_rise && (to_cnt_q != '0)) ||
                        ((VS_TIMEOUT != 0) && (to_cnt_q == TO_LAST)));

  ace_snap_regfile u_regfile (
    .clk          (clk),
    .rst_n        (reset_n),
    .clear_i      (load_start),
    .wr_i         (load_wr && in_win),
    .off_i        (loader_addr[6:0]),
    .data_i       (loader_data),
    .latch_i      (load_end),
    .sp_fix_i     (sp_fix),
    .sp_fix_val_i (SP_FIX_VALUE),
    .image_o      (reg_image),
    .snap_valid_o (snap_valid)
  );

  always_comb begin
    state_d    = state_q;
    max_addr_d = max_addr_q;
    to_cnt_d   = to_cnt_q;
    inj_cnt_d  = inj_cnt_q;
    sp_fixed_d = sp_fixed_q;
    if (load_start) begin
      state_d    = ST_LOAD;
      max_addr_d = '0;
      sp_fixed_d = 1'b0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (load_wr && (loader_addr > max_addr_q)) max_addr_d = loader_addr;
          if (!loader_en) begin
            state_d    = ST_WAIT_VS;
            to_cnt_d   = '0;
            sp_fixed_d = sp_fix;
          end
        end
        ST_WAIT_VS: begin
          if (to_cnt_q != '1) to_cnt_d = to_cnt_q + 21'd1;
          if (release_now) begin
            inj_cnt_d = '0;
            // Without a PC there is nothing to inject: cold boot from ROM.
            state_d   = snap_valid ? ST_INJECT : ST_IDLE;
          end
        end
        ST_INJECT: begin
          inj_cnt_d = inj_cnt_q + 4'd1;
          if (inj_cnt_q == INJ_LAST) state_d = ST_IDLE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      max_addr_q <= '0;
      to_cnt_q   <= '0;
      inj_cnt_q  <= '0;
      sp_fixed_q <= 1'b0;
      en_q       <= 1'b0;
      vs_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      max_addr_q <= max_addr_d;
      to_cnt_q   <= to_cnt_d;
      inj_cnt_q  <= inj_cnt_d;
      sp_fixed_q <= sp_fixed_d;
      en_q       <= loader_en;
      vs_q       <= vsync;
    end
  end

  assign cpu_reset = (state_q == ST_LOAD) || (state_q == ST_WAIT_VS);
  assign dir_set   = (state_q != ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign sp_fixed  = sp_fixed_q;

endmodule

// File: tb/tb_ace_snap_loader.sv
// Testbench for ace_snap_loader: randomized and directed snapshot loads,
// expectations from a table-driven register model pushed to a scoreboard.
// Monitor pops one record each time a load session ends (busy falls).
module tb_ace_snap_loader;

  localparam int INJ = 3;
  localparam int TMO = 100;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         loader_en = 1'b0;
  logic [15:0]  loader_addr = '0;
  logic [7:0]   loader_data = '0;
  logic         loader_wr = 1'b0;
  logic         vsync = 1'b0;
  logic         cpu_reset, dir_set, busy, snap_valid, sp_fixed;
  logic [211:0] reg_image;

  ace_snap_loader #(
    .REG_BASE      (16'h2100),
    .INJECT_CYCLES (INJ),
    .SP_FIXUP      (1'b1),
    .SP_FIX_VALUE  (16'hFFFE),
    .VS_TIMEOUT    (TMO)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .loader_en   (loader_en),
    .loader_addr (loader_addr),
    .loader_data (loader_data),
    .loader_wr   (loader_wr),
    .vsync       (vsync),
    .cpu_reset   (cpu_reset),
    .dir_set     (dir_set),
    .reg_image   (reg_image),
    .busy        (busy),
    .snap_valid  (snap_valid),
    .sp_fixed    (sp_fixed)
  );

  always #5 clk = ~clk;

  // Register window table: offset, destination lsb, width
  int tbl_off[29] = '{'h00,'h01,'h04,'h05,'h08,'h09,'h0C,'h0D,'h10,'h11,'h14,'h15,'h18,'h19,
                      'h1C,'h1D,'h20,'h21,'h24,'h25,'h28,'h29,'h2C,'h2D,'h30,'h34,'h38,'h3C,'h40};
  int tbl_lsb[29] = '{8,0,80,88,96,104,112,120,128,136,192,200,48,56,
                      64,72,24,16,144,152,160,168,176,184,208,210,211,32,40};
  int tbl_w[29]   = '{8,8,8,8,8,8,8,8,8,8,8,8,8,8,8,8,8,8,8,8,8,8,8,8,2,1,1,8,8};

  typedef struct packed {
    logic [211:0] img;
    logic         valid;
    logic         fixed;
    int           hold;   // cycles cpu_reset is seen high after loader_en is seen low
    int           inj;    // cycles dir_set stays high after cpu_reset falls
  } exp_t;

  exp_t        expq[$];
  logic [15:0] sess_addr[$];
  logic [7:0]  sess_data[$];
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model of one load session; vs_delay is the clk count from the
  // loader_en drop to the first usable vsync edge.
  function automatic exp_t predict(input int vs_delay);
    exp_t        e;
    logic [15:0] mx;
    logic        pcl, pch;
    int          off;
    e.img = '0;
    mx    = '0;
    pcl   = 1'b0;
    pch   = 1'b0;
    foreach (sess_addr[i]) begin
      if (sess_addr[i] > mx) mx = sess_addr[i];
      off = int'(sess_addr[i]) - 'h2100;
      if (off >= 0 && off < 128) begin
        for (int k = 0; k < 29; k++) begin
          if (off == tbl_off[k]) begin
            for (int b = 0; b < tbl_w[k]; b++) e.img[tbl_lsb[k] + b] = sess_data[i][b];
            if (off == 'h1C) pcl = 1'b1;
            if (off == 'h1D) pch = 1'b1;
          end
        end
      end
    end
    e.valid = pcl && pch;
    e.fixed = (e.img[63:48] > mx);
    if (e.fixed) e.img[63:48] = 16'hFFFE;
    e.hold = ((vs_delay < TMO) ? vs_delay : TMO) + 1;
    e.inj  = e.valid ? INJ : 0;
    return e;
  endfunction

  task automatic start_load();
    sess_addr.delete();
    sess_data.delete();
    loader_en = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    loader_addr = a;
    loader_data = d;
    loader_wr   = 1'b1;
    @(posedge clk);
    #1;
    loader_wr = 1'b0;
    sess_addr.push_back(a);
    sess_data.push_back(d);
  endtask

  // Drop loader_en, raise vsync d clks later (or at once plus again at d when
  // coincident), then wait for the session to finish.
  task automatic end_load(input int d, input bit coincident);
    expq.push_back(predict(d));
    loader_en = 1'b0;
    if (coincident) begin
      vsync = 1'b1;
      repeat (3) @(posedge clk);
      #1 vsync = 1'b0;
      repeat (d - 3) @(posedge clk);
    end else begin
      repeat (d) @(posedge clk);
    end
    #1 vsync = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (!busy) break;
      @(posedge clk);
      #1;
    end
    chk("idle_after_release", 256'(busy), 256'(0));
    vsync = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Monitor: measures the release timing and compares on every session end
  initial begin
    exp_t e;
    int   hold_cnt;
    int   inj_cnt;
    logic busy_prev;
    hold_cnt  = 0;
    inj_cnt   = 0;
    busy_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        hold_cnt  = 0;
        inj_cnt   = 0;
        busy_prev = 1'b0;
      end else begin
        if (loader_en) begin
          hold_cnt = 0;
          inj_cnt  = 0;
        end else if (busy && cpu_reset) begin
          hold_cnt++;
        end else if (busy && dir_set) begin
          inj_cnt++;
        end
        if (busy_prev && !busy) begin
          if (expq.size() == 0) begin
            chk("unexpected_session_end", 256'(1), 256'(0));
          end else begin
            e = expq.pop_front();
            chk("reg_image",     256'(reg_image),  256'(e.img));
            chk("snap_valid",    256'(snap_valid), 256'(e.valid));
            chk("sp_fixed",      256'(sp_fixed),   256'(e.fixed));
            chk("hold_cycles",   256'(hold_cnt),   256'(e.hold));
            chk("inject_cycles", 256'(inj_cnt),    256'(e.inj));
          end
        end
        busy_prev = busy;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] a;
    int          n;
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cpu_reset",  256'(cpu_reset),  256'(0));
    chk("rst_dir_set",    256'(dir_set),    256'(0));
    chk("rst_busy",       256'(busy),       256'(0));
    chk("rst_snap_valid", 256'(snap_valid), 256'(0));
    chk("rst_sp_fixed",   256'(sp_fixed),   256'(0));
    chk("rst_image",      256'(reg_image),  256'(0));
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Basic load, SP inside loaded memory
    start_load();
    wr(16'h2121, 8'h5A); wr(16'h2120, 8'h44); wr(16'h211C, 8'h00);
    wr(16'h211D, 8'h40); wr(16'h2119, 8'h7F); wr(16'h2118, 8'h00);
    wr(16'h7FFF, 8'h00);
    chk("load_cpu_reset", 256'(cpu_reset), 256'(1));
    chk("load_dir_set",   256'(dir_set),   256'(1));
    end_load(10, 1'b0);

    // SP above highest loaded address gets repaired
    start_load();
    wr(16'h2121, 8'h5A); wr(16'h2120, 8'h44); wr(16'h211C, 8'h00);
    wr(16'h211D, 8'h40); wr(16'h2119, 8'hFF); wr(16'h2118, 8'h00);
    wr(16'h7FFF, 8'h00);
    end_load(7, 1'b0);

    // PC high byte missing: cold boot
    start_load();
    wr(16'h2121, 8'h5A); wr(16'h211C, 8'h00); wr(16'h2118, 8'h00); wr(16'h8000, 8'h01);
    end_load(5, 1'b0);

    // vsync edge coincident with loader_en drop is ignored
    start_load();
    wr(16'h211C, 8'h34); wr(16'h211D, 8'h12); wr(16'h2130, 8'hFE); wr(16'h2134, 8'h01);
    end_load(12, 1'b1);

    // No vsync: release on timeout
    start_load();
    wr(16'h211C, 8'h00); wr(16'h211D, 8'h01); wr(16'h2138, 8'h01); wr(16'hC000, 8'h00);
    end_load(150, 1'b0);

    // Reload while waiting for vsync discards the first capture
    start_load();
    wr(16'h2101, 8'hAA); wr(16'h211C, 8'h11); wr(16'h211D, 8'h22);
    loader_en = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    start_load();
    wr(16'h2100, 8'h55); wr(16'h211D, 8'h33); wr(16'h211C, 8'h44); wr(16'h211C, 8'h45);
    end_load(9, 1'b0);

    // Randomized sessions
    for (int s = 0; s < 20; s++) begin
      start_load();
      n = $urandom_range(3, 12);
      for (int k = 0; k < n; k++) begin
        case ($urandom_range(0, 9))
          0, 1, 2, 3, 4, 5: a = 16'h2100 + 16'(tbl_off[$urandom_range(0, 28)]);
          6, 7:             a = 16'h2100 + 16'($urandom_range(0, 127));
          default:          a = 16'($urandom);
        endcase
        wr(a, 8'($urandom));
        if (k == n / 2 && $urandom_range(0, 9) < 7) begin
          wr(16'h211C, 8'($urandom));
          wr(16'h211D, 8'($urandom));
        end
      end
      end_load(int'($urandom_range(2, 130)), 1'b0);
    end

    // Asynchronous reset in the middle of a load
    start_load();
    wr(16'h2101, 8'h12);
    chk("write_lands_next_cycle", 256'(reg_image[7:0]), 256'(8'h12));
    #3 reset_n = 1'b0;
    #1;
    chk("arst_cpu_reset",  256'(cpu_reset),  256'(0));
    chk("arst_dir_set",    256'(dir_set),    256'(0));
    chk("arst_busy",       256'(busy),       256'(0));
    chk("arst_snap_valid", 256'(snap_valid), 256'(0));
    chk("arst_sp_fixed",   256'(sp_fixed),   256'(0));
    chk("arst_image",      256'(reg_image),  256'(0));
    loader_en = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("post_arst_busy",  256'(busy),      256'(0));
    chk("post_arst_image", 256'(reg_image), 256'(0));

    chk("scoreboard_drained", 256'(expq.size()), 256'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
